multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier_if.sv | 30 +++
 rtl/multiplier.sv | 125 ++++++++++++
 tb/tb_multiplier.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/multiplier_if.sv
// Handshake/data bundle for the sequential shift-add multiplier.
//   iEn     : enable, gates operand capture and each iteration step
//   iClr    : synchronous clear, aborts the operation and zeroes outputs
//   iData0  : multiplicand (BITWIDTH bits)
//   iData1  : multiplier   (BITWIDTH bits)
//   oData   : registered full-width product (2*BITWIDTH bits)
//   oValid  : one-cycle pulse, oData holds a new product
//   oBusy   : high while an operation is in progress
// Modports: master drives the inputs, slave (the multiplier) drives the outputs.
interface multiplier_if #(
  parameter int BITWIDTH = 32
);
  logic                    iEn;
  logic                    iClr;
  logic [BITWIDTH-1:0]     iData0;
  logic [BITWIDTH-1:0]     iData1;
  logic [2*BITWIDTH-1:0]   oData;
  logic                    oValid;
  logic                    oBusy;

  modport master (
    output iEn, iClr, iData0, iData1,
    input  oData, oValid, oBusy
  );

  modport slave (
    input  iEn, iClr, iData0, iData1,
    output oData, oValid, oBusy
  );
endinterface

// File: rtl/multiplier.sv
// Sequential radix-2 shift-add multiplier, one multiplier bit per enabled cycle.
// Ports:
//   iClk : clock, all state updates on the rising edge
//   iRst : asynchronous active-high reset
//   bus  : multiplier_if.slave (iEn, iClr, iData0, iData1, oData, oValid, oBusy)
// Latency with iEn held high: capture edge plus BITWIDTH processing edges;
// oValid pulses for one cycle while the block is already back in IDLE.
// Configuration macro: MULTIPLIER_SIGNED_EN selects two's-complement operands
// and product; when undefined the block is purely unsigned.
module multiplier #(
  parameter int BITWIDTH = 32
) (
  input  logic        iClk,
  input  logic        iRst,
  multiplier_if.slave bus
);

  localparam int PW = 2 * BITWIDTH;
  localparam int CW = $clog2(BITWIDTH);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         mcand_q, mcand_d;   // multiplicand, pre-extended to product width
  logic [BITWIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [PW-1:0]         data_q, data_d;
  logic                  valid_q, valid_d;

  logic [PW-1:0]         mcand_ext;
  logic [PW-1:0]         addend;
  logic [PW-1:0]         acc_sum;
  logic                  last_bit;

  assign last_bit = (cnt_q == CW'(BITWIDTH - 1));

  always_comb begin
`ifdef MULTIPLIER_SIGNED_EN
    mcand_ext = {{BITWIDTH{bus.iData0[BITWIDTH-1]}}, bus.iData0};
`else
    mcand_ext = {{BITWIDTH{1'b0}}, bus.iData0};
`endif
  end

  always_comb begin
    addend = mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0;
`ifdef MULTIPLIER_SIGNED_EN
    // MSB of a two's-complement multiplier carries weight -2^(BITWIDTH-1)
    acc_sum = last_bit ? (acc_q - addend) : (acc_q + addend);
`else
    acc_sum = acc_q + addend;
`endif
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    data_d   = data_q;
    valid_d  = 1'b0;

    if (bus.iClr) begin
      // clear wins over enable: abort, zero everything, no capture
      state_d  = IDLE;
      mcand_d  = '0;
      mplier_d = '0;
      cnt_d    = '0;
      acc_d    = '0;
      data_d   = '0;
    end else if (bus.iEn) begin
      case (state_q)
        IDLE: begin
          mcand_d  = mcand_ext;
          mplier_d = bus.iData1;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = BUSY;
        end
        BUSY: begin
          acc_d = acc_sum;
          if (last_bit) begin
            data_d  = acc_sum;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.oData  = data_q;
  assign bus.oValid = valid_q;
  assign bus.oBusy  = (state_q == BUSY);

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier (BITWIDTH=32). Stimulus pushes the
// hand-computed product and the cycle it is due; a negedge monitor pops and
// compares whenever oValid is seen. Expected values follow the build's
// MULTIPLIER_SIGNED_EN setting.
module tb_multiplier;
  localparam int W = 32;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  multiplier_if #(.BITWIDTH(W)) bus ();

  multiplier #(.BITWIDTH(W)) u_dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  int unsigned cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    logic [2*W-1:0] data;
    int unsigned    due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // monitor: every oValid pulse must match the oldest outstanding expectation
  always @(negedge iClk) begin
    if (bus.oValid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(bus.oValid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("product", bus.oData, mon_e.data);
        check("valid_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  // called at a negedge with the DUT idle; returns at the negedge oValid is seen
  task automatic start_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] prod, input int unsigned stall);
    int unsigned k;
    bus.iData0 = a;
    bus.iData1 = b;
    bus.iEn    = 1'b1;
    sb.push_back('{data: prod, due: cyc + 1 + W + stall});
    @(negedge iClk);
    bus.iData0 = ~a;  // must be ignored while busy
    bus.iData1 = ~b;
    check("busy_after_capture", 64'(bus.oBusy), 64'd1);
    if (stall > 0) begin
      repeat (3) @(negedge iClk);
      bus.iEn = 1'b0;
      repeat (stall) begin
        @(negedge iClk);
        check("busy_in_stall", 64'(bus.oBusy), 64'd1);
      end
      bus.iEn = 1'b1;
    end
    k = 0;
    while (bus.oValid !== 1'b1 && k < 100) begin
      @(negedge iClk);
      k++;
    end
    if (bus.oValid !== 1'b1) check("valid_timeout", 64'(bus.oValid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst       = 1'b1;
    bus.iEn    = 1'b0;
    bus.iClr   = 1'b0;
    bus.iData0 = '0;
    bus.iData1 = '0;
    #12;
    check("rst_odata",  bus.oData, 64'd0);
    check("rst_ovalid", 64'(bus.oValid), 64'd0);
    check("rst_obusy",  64'(bus.oBusy), 64'd0);
    @(negedge iClk);
    iRst = 1'b0;

    // back-to-back: one product every W+1 cycles
    start_mul(32'd10, 32'd20, 64'd200, 0);
    start_mul(32'd10, 32'd20, 64'd200, 0);
    start_mul(32'd10, 32'd20, 64'd200, 0);
`ifdef MULTIPLIER_SIGNED_EN
    start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 0);
    start_mul(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    start_mul(32'h8000_0000, 32'd2, 64'hFFFF_FFFF_0000_0000, 0);
`else
    start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    start_mul(32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, 0);
    start_mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 0);
`endif
    start_mul(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    start_mul(32'd0, 32'h0000_1234, 64'd0, 0);
    start_mul(32'd123, 32'd456, 64'd56088, 0);
    start_mul(32'd1000, 32'd1000, 64'd1000000, 5);
    bus.iEn = 1'b0;
    repeat (3) @(negedge iClk);
    check("hold_odata", bus.oData, 64'd1000000);
    check("idle_obusy", 64'(bus.oBusy), 64'd0);

    // synchronous clear mid-operation, held with iEn high
    bus.iData0 = 32'd12345;
    bus.iData1 = 32'd678;
    bus.iEn    = 1'b1;
    @(negedge iClk);
    repeat (10) @(negedge iClk);
    bus.iClr = 1'b1;
    @(negedge iClk);
    check("clr_odata",  bus.oData, 64'd0);
    check("clr_ovalid", 64'(bus.oValid), 64'd0);
    check("clr_obusy",  64'(bus.oBusy), 64'd0);
    repeat (3) begin
      @(negedge iClk);
      check("clr_no_capture", 64'(bus.oBusy), 64'd0);
    end
    bus.iClr = 1'b0;
    bus.iEn  = 1'b0;
    @(negedge iClk);

    // asynchronous reset mid-operation
    start_mul(32'd3, 32'd4, 64'd12, 0);
    bus.iData0 = 32'd99;
    bus.iData1 = 32'd99;
    @(negedge iClk);
    check("busy_before_rst", 64'(bus.oBusy), 64'd1);
    repeat (5) @(negedge iClk);
    #2 iRst = 1'b1;
    #1;
    check("arst_odata",  bus.oData, 64'd0);
    check("arst_ovalid", 64'(bus.oValid), 64'd0);
    check("arst_obusy",  64'(bus.oBusy), 64'd0);
    bus.iEn = 1'b0;
    #1 iRst = 1'b0;
    @(negedge iClk);
    check("post_rst_idle", 64'(bus.oBusy), 64'd0);
    start_mul(32'd7, 32'd6, 64'd42, 0);
    bus.iEn = 1'b0;

    repeat (3) @(negedge iClk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
